scc_mem_stage: RTL



---
 rtl/scc_pkg.sv | 17 +
 rtl/scc_mem_stage_if.sv | 43 ++++
 rtl/scc_mem_timer.sv | 26 ++
 rtl/scc_mem_stage.sv | 137 +++++++++++++
 4 files changed

// File: rtl/scc_pkg.sv
// rtl/scc_pkg.sv - shared widths, state encoding and flag indices for the SCC memory stage
package scc_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

endpackage

// File: rtl/scc_mem_stage_if.sv
// rtl/scc_mem_stage_if.sv - Execute, data-memory and Write-Back signals of the memory stage
interface scc_mem_stage_if;
  import scc_pkg::*;

  logic              ex_valid;
  logic              ex_ready;
  logic              ex_is_load;
  logic              ex_is_store;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_dest_reg;
  logic              ex_wr_en;
  logic [3:0]        ex_flags;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  logic              wb_valid;
  logic              wb_wr_en;
  logic [REG_W-1:0]  wb_dest_reg;
  logic [DATA_W-1:0] wb_data;
  logic [3:0]        wb_flags;
  logic              mem_fault;

  modport master (
    output ex_valid, ex_is_load, ex_is_store, ex_result, ex_store_data,
           ex_dest_reg, ex_wr_en, ex_flags, dmem_ack, dmem_rdata,
    input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_valid, wb_wr_en, wb_dest_reg, wb_data, wb_flags, mem_fault
  );

  modport slave (
    input  ex_valid, ex_is_load, ex_is_store, ex_result, ex_store_data,
           ex_dest_reg, ex_wr_en, ex_flags, dmem_ack, dmem_rdata,
    output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_valid, wb_wr_en, wb_dest_reg, wb_data, wb_flags, mem_fault
  );

endinterface

// File: rtl/scc_mem_timer.sv
// rtl/scc_mem_timer.sv - access timeout counter; expire flags the last permitted wait cycle
module scc_mem_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [7:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else if (clear) begin
      count_q <= 8'd0;
    end else if (enable) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expire = (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/scc_mem_stage.sv
// rtl/scc_mem_stage.sv - memory stage: passes ALU results through, performs loads/stores
// with a request/ack handshake and a bounded wait, and registers the Write-Back result.
module scc_mem_stage
  import scc_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  scc_mem_stage_if.slave  bus
);

  mem_state_t        state_q, state_d;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic              we_q, wr_en_q;
  logic [REG_W-1:0]  dest_q;
  logic [3:0]        flags_q;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_wr_en_q, wb_wr_en_d;
  logic              mem_fault_q, mem_fault_d;
  logic [REG_W-1:0]  wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [3:0]        wb_flags_q, wb_flags_d;

  logic accept, is_mem, expire, in_access;

  assign in_access = (state_q == ACCESS);
  assign accept    = bus.ex_valid && !in_access;
  assign is_mem    = bus.ex_is_load || bus.ex_is_store;

  scc_mem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept && is_mem),
    .enable (in_access && !bus.dmem_ack),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mem) state_d = ACCESS;
      ACCESS:  if (bus.dmem_ack || expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ack is tested before expire so a completion on the timeout edge retires normally.
  always_comb begin
    wb_valid_d  = 1'b0;
    wb_wr_en_d  = 1'b0;
    mem_fault_d = 1'b0;
    wb_dest_d   = wb_dest_q;
    wb_data_d   = wb_data_q;
    wb_flags_d  = wb_flags_q;
    case (state_q)
      IDLE: begin
        if (accept && !is_mem) begin
          wb_valid_d = 1'b1;
          wb_wr_en_d = bus.ex_wr_en;
          wb_dest_d  = bus.ex_dest_reg;
          wb_data_d  = bus.ex_result;
          wb_flags_d = bus.ex_flags;
        end
      end
      ACCESS: begin
        if (bus.dmem_ack) begin
          wb_valid_d = 1'b1;
          wb_wr_en_d = wr_en_q && !we_q;
          wb_dest_d  = dest_q;
          wb_data_d  = we_q ? addr_q : bus.dmem_rdata;
          wb_flags_d = flags_q;
        end else if (expire) begin
          wb_valid_d  = 1'b1;
          mem_fault_d = 1'b1;
          wb_dest_d   = dest_q;
          wb_flags_d  = flags_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      wr_en_q     <= 1'b0;
      dest_q      <= '0;
      flags_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_wr_en_q  <= 1'b0;
      mem_fault_q <= 1'b0;
      wb_dest_q   <= '0;
      wb_data_q   <= '0;
      wb_flags_q  <= '0;
    end else begin
      if (accept && is_mem) begin
        addr_q  <= bus.ex_result;
        wdata_q <= bus.ex_store_data;
        we_q    <= bus.ex_is_store && !bus.ex_is_load;
        wr_en_q <= bus.ex_wr_en;
        dest_q  <= bus.ex_dest_reg;
        flags_q <= bus.ex_flags;
      end
      wb_valid_q  <= wb_valid_d;
      wb_wr_en_q  <= wb_wr_en_d;
      mem_fault_q <= mem_fault_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
      wb_flags_q  <= wb_flags_d;
    end
  end

  assign bus.ex_ready    = !in_access;
  assign bus.dmem_req    = in_access;
  assign bus.dmem_we     = in_access && we_q;
  assign bus.dmem_addr   = addr_q;
  assign bus.dmem_wdata  = wdata_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_wr_en    = wb_wr_en_q;
  assign bus.wb_dest_reg = wb_dest_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_flags    = wb_flags_q;
  assign bus.mem_fault   = mem_fault_q;

endmodule
